// File: rtl/serializer_pkg.sv
// Shared types and limits for the parallel-to-serial feeder.
package serializer_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StGap
    } ser_state_t;

    localparam int unsigned MaxGap = 15;

endpackage

// File: rtl/hold_buffer.sv
// One-entry register slice that parks a word while the current word is still shifting.
module hold_buffer
    import serializer_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic [WIDTH-1:0] data
);

    logic             full_q;
    logic [WIDTH-1:0] data_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            full_q <= 1'b0;
            data_q <= '0;
        end else if (push) begin
            full_q <= 1'b1;
            data_q <= push_data;
        end else if (pop) begin
            full_q <= 1'b0;
        end
    end

    assign full = full_q;
    assign data = data_q;

endmodule

// File: rtl/bit_serializer.sv
// Parallel-to-serial feeder: valid/ready word input, one bit per clock out, optional idle gap.
module bit_serializer
    import serializer_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter bit          MSB_FIRST = 1'b1,
    parameter int unsigned GAP       = 0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             serial_out,
    output logic             serial_valid,
    output logic             word_done,
    output logic             busy
);

    localparam int unsigned     CntW    = $clog2(WIDTH);
    localparam int unsigned     GapEff  = (GAP > MaxGap) ? MaxGap : GAP;
    localparam logic [CntW-1:0] BitLast = CntW'(WIDTH - 1);
    localparam logic [3:0]      GapLast = 4'((GapEff > 0) ? GapEff - 1 : 0);

    ser_state_t       state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CntW-1:0]  bit_cnt_q, bit_cnt_d;
    logic [3:0]       gap_cnt_q, gap_cnt_d;

    logic serial_out_q, serial_out_d;
    logic serial_valid_q, serial_valid_d;
    logic word_done_q, word_done_d;
    logic busy_q, busy_d;

    logic             hold_full, hold_full_d;
    logic [WIDTH-1:0] hold_data;
    logic             xfer, avail, load, push, pop, head_bit;
    logic [WIDTH-1:0] next_word, shifted;

    hold_buffer #(
        .WIDTH (WIDTH)
    ) u_hold (
        .clock     (clock),
        .reset     (reset),
        .push      (push),
        .push_data (in_data),
        .pop       (pop),
        .full      (hold_full),
        .data      (hold_data)
    );

    assign in_ready  = !hold_full && !reset;
    assign xfer      = in_valid && in_ready;
    assign avail     = hold_full || xfer;
    assign next_word = hold_full ? hold_data : in_data;
    assign shifted   = MSB_FIRST ? {shreg_q[WIDTH-2:0], 1'b0} : {1'b0, shreg_q[WIDTH-1:1]};

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        gap_cnt_d = gap_cnt_q;
        load      = 1'b0;

        case (state_q)
            StIdle: begin
                if (avail) load = 1'b1;
            end
            StShift: begin
                shreg_d = shifted;
                if (bit_cnt_q == BitLast) begin
                    if (GapEff == 0) begin
                        if (avail) load = 1'b1;
                        else       state_d = StIdle;
                    end else begin
                        state_d   = StGap;
                        gap_cnt_d = '0;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end
            end
            StGap: begin
                if (gap_cnt_q == GapLast) begin
                    if (avail) load = 1'b1;
                    else       state_d = StIdle;
                end else begin
                    gap_cnt_d = gap_cnt_q + 4'd1;
                end
            end
            default: state_d = StIdle;
        endcase

        if (load) begin
            state_d   = StShift;
            shreg_d   = next_word;
            bit_cnt_d = '0;
        end
    end

    // Only a transfer that isn't loaded straight into the shifter is parked.
    assign push        = xfer && !load;
    assign pop         = load && hold_full;
    assign hold_full_d = push || (hold_full && !pop);

    // Outputs are registered, so they are computed from the next-state values.
    always_comb begin
        head_bit       = MSB_FIRST ? shreg_d[WIDTH-1] : shreg_d[0];
        serial_valid_d = (state_d == StShift);
        serial_out_d   = serial_valid_d && head_bit;
        word_done_d    = serial_valid_d && (bit_cnt_d == BitLast);
        busy_d         = (state_d != StIdle) || hold_full_d;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q        <= StIdle;
            shreg_q        <= '0;
            bit_cnt_q      <= '0;
            gap_cnt_q      <= '0;
            serial_out_q   <= 1'b0;
            serial_valid_q <= 1'b0;
            word_done_q    <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            shreg_q        <= shreg_d;
            bit_cnt_q      <= bit_cnt_d;
            gap_cnt_q      <= gap_cnt_d;
            serial_out_q   <= serial_out_d;
            serial_valid_q <= serial_valid_d;
            word_done_q    <= word_done_d;
            busy_q         <= busy_d;
        end
    end

    assign serial_out   = serial_out_q;
    assign serial_valid = serial_valid_q;
    assign word_done    = word_done_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_bit_serializer.sv
// Bench for bit_serializer: four configurations driven from shared inputs, checked against
// a word-schedule model plus directed vectors.
module tb_bit_serializer;

    localparam int NCYC = 1024;
    localparam int ND   = 4;
    localparam int PW [ND] = '{8, 8, 8, 5};
    localparam bit PM [ND] = '{1'b1, 1'b0, 1'b1, 1'b0};
    localparam int PG [ND] = '{0, 0, 2, 1};

    logic       clock = 1'b1;
    logic       reset;
    logic       in_valid;
    logic [7:0] in_data;
    logic       rdy [ND];
    logic       so  [ND];
    logic       sv  [ND];
    logic       wd  [ND];
    logic       bz  [ND];

    always #5 clock = ~clock;

    bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .GAP(0)) u_d0 (
        .clock(clock), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_ready(rdy[0]), .serial_out(so[0]), .serial_valid(sv[0]),
        .word_done(wd[0]), .busy(bz[0]));
    bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .GAP(0)) u_d1 (
        .clock(clock), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_ready(rdy[1]), .serial_out(so[1]), .serial_valid(sv[1]),
        .word_done(wd[1]), .busy(bz[1]));
    bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .GAP(2)) u_d2 (
        .clock(clock), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_ready(rdy[2]), .serial_out(so[2]), .serial_valid(sv[2]),
        .word_done(wd[2]), .busy(bz[2]));
    bit_serializer #(.WIDTH(5), .MSB_FIRST(1'b0), .GAP(1)) u_d3 (
        .clock(clock), .reset(reset), .in_data(in_data[4:0]), .in_valid(in_valid),
        .in_ready(rdy[3]), .serial_out(so[3]), .serial_valid(sv[3]),
        .word_done(wd[3]), .busy(bz[3]));

    // Expected per-cycle outputs, filled in as words are accepted.
    bit   m_sv [ND][NCYC];
    bit   m_so [ND][NCYC];
    bit   m_wd [ND][NCYC];
    bit   m_bz [ND][NCYC];
    int   m_next_free [ND];
    int   m_hold_until [ND];

    logic obs_sv  [ND][NCYC];
    logic obs_so  [ND][NCYC];
    logic obs_wd  [ND][NCYC];
    logic obs_bz  [ND][NCYC];
    logic obs_rdy [ND][NCYC];

    int cyc;
    int checks;
    int failures;

    typedef struct {
        logic       rst;
        logic       vld;
        logic [7:0] data;
        logic       e_rdy;
        logic       e_sv;
        logic       e_so;
        logic       e_wd;
        logic       e_bz;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(string name, int k, int c, logic act, logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s dut=%0d cyc=%0d got=%b exp=%b", name, k, c, act, exp);
        end
    endtask

    // A word accepted at cycle t starts at max(t+1, end of previous word + gap).
    task automatic model_step(int k, logic r, logic v, logic [7:0] d);
        logic er;
        int   st;
        int   w;
        int   g;
        w  = PW[k];
        g  = PG[k];
        er = !r && !(cyc <= m_hold_until[k]);
        chk("in_ready", k, cyc, rdy[k], er);
        if (cyc > 0) begin
            chk("serial_valid", k, cyc, sv[k], m_sv[k][cyc]);
            chk("serial_out", k, cyc, so[k], m_so[k][cyc]);
            chk("word_done", k, cyc, wd[k], m_wd[k][cyc]);
            chk("busy", k, cyc, bz[k], m_bz[k][cyc]);
        end
        if (r) begin
            for (int i = cyc + 1; i < NCYC; i++) begin
                m_sv[k][i] = 1'b0;
                m_so[k][i] = 1'b0;
                m_wd[k][i] = 1'b0;
                m_bz[k][i] = 1'b0;
            end
            m_hold_until[k] = cyc;
            m_next_free[k]  = 0;
        end else if (v && er) begin
            st = (cyc + 1 > m_next_free[k]) ? cyc + 1 : m_next_free[k];
            if (st + w + g >= NCYC) begin
                checks++;
                failures++;
                $display("FAIL model_range dut=%0d cyc=%0d got=%0d exp<%0d", k, cyc, st, NCYC);
            end else begin
                for (int j = 0; j < w; j++) begin
                    m_sv[k][st+j] = 1'b1;
                    m_so[k][st+j] = PM[k] ? d[w-1-j] : d[j];
                end
                m_wd[k][st+w-1] = 1'b1;
                for (int i = cyc + 1; i < st + w + g; i++) m_bz[k][i] = 1'b1;
                if (st > cyc + 1) m_hold_until[k] = st - 1;
                m_next_free[k] = st + w + g;
            end
        end
    endtask

    task automatic step();
        if (cyc >= NCYC - 1) begin
            $display("FAIL cycle_budget cyc=%0d limit=%0d", cyc, NCYC - 1);
            $fatal(1, "cycle budget exhausted");
        end
        @(negedge clock);
        for (int k = 0; k < ND; k++) begin
            obs_sv[k][cyc]  = sv[k];
            obs_so[k][cyc]  = so[k];
            obs_wd[k][cyc]  = wd[k];
            obs_bz[k][cyc]  = bz[k];
            obs_rdy[k][cyc] = rdy[k];
            model_step(k, reset, in_valid, in_data);
        end
        @(posedge clock);
        #1;
        cyc++;
    endtask

    task automatic drive(logic r, logic v, logic [7:0] d);
        reset    = r;
        in_valid = v;
        in_data  = d;
        step();
    endtask

    function automatic void add(logic r, logic v, logic [7:0] d, logic e_rdy, logic e_sv,
                                logic e_so, logic e_wd, logic e_bz);
        vec_t x;
        x.rst = r;  x.vld = v;  x.data = d;
        x.e_rdy = e_rdy;  x.e_sv = e_sv;  x.e_so = e_so;  x.e_wd = e_wd;  x.e_bz = e_bz;
        tbl.push_back(x);
    endfunction

    initial begin
        logic [7:0] w;
        int         base;
        logic       e;

        cyc      = 0;
        checks   = 0;
        failures = 0;
        for (int k = 0; k < ND; k++) begin
            m_next_free[k]  = 0;
            m_hold_until[k] = -1;
        end

        // DUT0 vectors: single word, then back-to-back with upstream stalled on hold.
        add(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        add(1'b0, 1'b1, 8'hB2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        w = 8'hB2;
        for (int i = 0; i < 8; i++) add(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, w[7-i], i == 7, 1'b1);
        add(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        add(1'b0, 1'b1, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        w = 8'hA5;
        add(1'b0, 1'b1, 8'h3C, 1'b1, 1'b1, w[7], 1'b0, 1'b1);
        for (int i = 1; i < 8; i++)
            add(1'b0, 1'b1, 8'(i * 17), 1'b0, 1'b1, w[7-i], i == 7, 1'b1);
        w = 8'h3C;
        for (int i = 0; i < 8; i++) add(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, w[7-i], i == 7, 1'b1);
        add(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        repeat (3) drive(1'b1, 1'b0, 8'h00);

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].rst, tbl[i].vld, tbl[i].data);
            chk("tbl_ready", 0, cyc - 1, obs_rdy[0][cyc-1], tbl[i].e_rdy);
            chk("tbl_valid", 0, cyc - 1, obs_sv[0][cyc-1], tbl[i].e_sv);
            chk("tbl_out", 0, cyc - 1, obs_so[0][cyc-1], tbl[i].e_so);
            chk("tbl_done", 0, cyc - 1, obs_wd[0][cyc-1], tbl[i].e_wd);
            chk("tbl_busy", 0, cyc - 1, obs_bz[0][cyc-1], tbl[i].e_bz);
        end

        // LSB-first: 0x01 leaves as a single 1 followed by seven 0s.
        repeat (15) drive(1'b0, 1'b0, 8'h00);
        base = cyc;
        drive(1'b0, 1'b1, 8'h01);
        repeat (12) drive(1'b0, 1'b0, 8'h00);
        for (int j = 0; j < 8; j++) begin
            chk("lsb_valid", 1, base + 1 + j, obs_sv[1][base+1+j], 1'b1);
            chk("lsb_out", 1, base + 1 + j, obs_so[1][base+1+j], j == 0);
        end
        chk("lsb_end", 1, base + 9, obs_sv[1][base+9], 1'b0);

        // GAP=2: two queued 0xFF words separated by two idle-low cycles.
        repeat (15) drive(1'b0, 1'b0, 8'h00);
        base = cyc;
        drive(1'b0, 1'b1, 8'hFF);
        drive(1'b0, 1'b1, 8'hFF);
        repeat (25) drive(1'b0, 1'b0, 8'h00);
        chk("gap_second_ready", 2, base + 1, obs_rdy[2][base+1], 1'b1);
        for (int j = 0; j < 18; j++) begin
            e = !(j == 8 || j == 9);
            chk("gap_valid", 2, base + 1 + j, obs_sv[2][base+1+j], e);
            chk("gap_out", 2, base + 1 + j, obs_so[2][base+1+j], e);
        end
        chk("gap_end", 2, base + 19, obs_sv[2][base+19], 1'b0);

        // Reset on the 4th bit of 0xF0 with 0x0F parked in hold.
        repeat (15) drive(1'b0, 1'b0, 8'h00);
        base = cyc;
        drive(1'b0, 1'b1, 8'hF0);
        drive(1'b0, 1'b1, 8'h0F);
        repeat (2) drive(1'b0, 1'b0, 8'h00);
        drive(1'b1, 1'b0, 8'h00);
        repeat (16) drive(1'b0, 1'b0, 8'h00);
        chk("rst_hold_full", 0, base + 3, obs_rdy[0][base+3], 1'b0);
        chk("rst_4th_bit", 0, base + 4, obs_so[0][base+4], 1'b1);
        chk("rst_ready_low", 0, base + 4, obs_rdy[0][base+4], 1'b0);
        chk("rst_ready_back", 0, base + 5, obs_rdy[0][base+5], 1'b1);
        chk("rst_busy", 0, base + 5, obs_bz[0][base+5], 1'b0);
        for (int j = base + 1; j <= base + 20; j++)
            chk("rst_no_done", 0, j, obs_wd[0][j], 1'b0);
        for (int j = base + 5; j <= base + 20; j++)
            chk("rst_no_valid", 0, j, obs_sv[0][j], 1'b0);

        // Random traffic with occasional resets, checked against the schedule model.
        repeat (500) begin
            drive($urandom_range(0, 63) == 0, $urandom_range(0, 3) != 0, 8'($urandom));
        end
        repeat (20) drive(1'b0, 1'b0, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bit_serializer.md
Name: bit_serializer

Overview:
- Upstream feeder for the serial-input sequence-detector FSM.
- Accepts parallel words over a valid/ready handshake and shifts them out one bit per clock on serial_out, qualified by serial_valid.
- Holds one word in a buffer while the current word shifts, so back-to-back words stream without bubbles.
- Optionally inserts a fixed idle gap between words, so the downstream FSM sees a defined 0 level between frames.

Parameters:
- WIDTH, 8: bits per word; legal range 2..32.
- MSB_FIRST, 1: 1 shifts bit WIDTH-1 first; 0 shifts bit 0 first.
- GAP, 0: idle cycles inserted after each word; legal range 0..15.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- in_data  input  WIDTH  parallel word to serialize.
- in_valid  input  1  in_data is valid this cycle.
- in_ready  output  1  block can accept a word this cycle.
- serial_out  output  1  current serial bit; 0 whenever serial_valid=0.
- serial_valid  output  1  serial_out carries a data bit this cycle.
- word_done  output  1  one-cycle pulse coincident with the last bit of each word.
- busy  output  1  high in SHIFT or GAP, or while the hold buffer is full.

Behaviour:
- Clock and reset: one clock, `clock`. Reset is synchronous and active-high on port `reset`. All outputs are registered except in_ready.
- Reset values:
  - state=IDLE, shift register=0, bit counter=0, gap counter=0, hold buffer empty.
  - serial_out=0, serial_valid=0, word_done=0, busy=0.
  - in_ready=0 while reset is high; in_ready=1 in the first cycle after reset deasserts.
- Handshake:
  - in_ready = !hold_full && !reset.
  - A transfer occurs on a cycle with in_valid && in_ready.
  - in_data is sampled only on a transfer.
  - in_valid without in_ready has no effect; the upstream must hold the word.
- Next-word source ("next available"):
  - The hold buffer, if full.
  - Otherwise, a word being transferred this cycle (bypass).
- States:
  - IDLE:
    - If a next word is available, load it into the shift register and go to SHIFT.
    - First bit appears on serial_out with serial_valid=1 in the following cycle.
    - Latency from transfer cycle N to first valid bit is cycle N+1.
  - SHIFT:
    - One bit per cycle; bit counter runs 0..WIDTH-1.
    - On the last bit (counter=WIDTH-1), word_done=1 in the same cycle.
    - At the end of the last bit with GAP=0: if a next word is available, load it and stay in SHIFT (no bubble). Otherwise go to IDLE.
    - At the end of the last bit with GAP>0: go to GAP.
  - GAP:
    - serial_valid=0, serial_out=0 for exactly GAP cycles.
    - After the last gap cycle, behave as IDLE: load the next word if available, else go to IDLE.
- Hold buffer:
  - A transfer that is not consumed by a load in the same cycle fills the hold buffer.
  - A load from the hold buffer empties it.
  - A load from the hold buffer and a new transfer in the same cycle are impossible, because in_ready=0 while the buffer is full.
- Bit order: MSB_FIRST selects the left or right shift. The shift register shifts in zeros.
- Throughput:
  - GAP=0: continuous stream, WIDTH valid bits per WIDTH cycles.
  - Otherwise: WIDTH+GAP cycles per word.
- Reset mid-word: the current word and the hold buffer are discarded. Outputs return to reset values in the next cycle and no word_done is emitted.
- Counter widths: bit counter is $clog2(WIDTH) bits; gap counter is 4 bits. No wrap beyond the terminal values.

Decomposition:
- Package serializer_pkg:
  - typedef enum logic [1:0] {IDLE, SHIFT, GAP} ser_state_t.
  - Localparam max GAP = 15.
- Sub-module: one natural split, `hold_buffer`, a one-entry valid/ready register slice with full flag, load and pop. The FSM and shift datapath stay in bit_serializer.

Test Plan:
- Reset, then drive in_data=8'b1011_0010 with in_valid for 1 cycle (MSB_FIRST=1, GAP=0) -> serial_out = 1,0,1,1,0,0,1,0 on cycles N+1..N+8 with serial_valid=1; word_done only on cycle N+8; IDLE afterward.
- Words 0xA5 then 0x3C offered back-to-back, in_valid held high -> second word accepted into hold (in_ready drops to 0 until the pop); 16 consecutive valid bits 10100101_00111100 with no bubble; two word_done pulses 8 cycles apart.
- MSB_FIRST=0, word 0x01 -> first serial bit 1, then seven 0s.
- GAP=2, two queued words 0xFF, 0xFF -> 8 ones, 2 cycles with serial_valid=0 and serial_out=0, then 8 ones.
- Assert reset on the 4th bit of 0xF0 with a word in hold -> next cycle serial_valid=0, busy=0, in_ready=0 during reset, 1 after; no word_done; the held word is never emitted.
- in_valid held high with hold full for 5 cycles, in_data changing -> only the word present at the in_ready=1 cycle is serialized.
